// File: rtl/reg_bus_arbiter.sv
// rtl/reg_bus_arbiter.sv - round-robin arbiter sharing one register-map port between two requesters
module reg_bus_arbiter #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  m0_req_i,
    input  logic                  m0_we_i,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [DATA_WIDTH-1:0] m0_wdata_i,
    output logic                  m0_ack_o,
    output logic [DATA_WIDTH-1:0] m0_rdata_o,
    input  logic                  m1_req_i,
    input  logic                  m1_we_i,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [DATA_WIDTH-1:0] m1_wdata_i,
    output logic                  m1_ack_o,
    output logic [DATA_WIDTH-1:0] m1_rdata_o,
    output logic [1:0]            grant_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] write_data_o,
    output logic                  write_en_o,
    output logic                  read_en_o,
    input  logic [DATA_WIDTH-1:0] read_data_i
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, ACK} state_t;

    state_t                state;
    logic                  owner;
    logic                  lat_we;
    logic                  last_grant;
    logic                  pick_m1;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    // On a tie the requester not served last wins; last_grant = 1 means m1.
    always_comb begin
        pick_m1   = m1_req_i && (!m0_req_i || !last_grant);
        sel_we    = pick_m1 ? m1_we_i    : m0_we_i;
        sel_addr  = pick_m1 ? m1_addr_i  : m0_addr_i;
        sel_wdata = pick_m1 ? m1_wdata_i : m0_wdata_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            owner        <= 1'b0;
            lat_we       <= 1'b0;
            last_grant   <= 1'b1;
            grant_o      <= 2'b00;
            addr_o       <= '0;
            write_data_o <= '0;
            write_en_o   <= 1'b0;
            read_en_o    <= 1'b0;
            m0_ack_o     <= 1'b0;
            m1_ack_o     <= 1'b0;
            m0_rdata_o   <= '0;
            m1_rdata_o   <= '0;
        end else begin
            write_en_o <= 1'b0;
            read_en_o  <= 1'b0;
            m0_ack_o   <= 1'b0;
            m1_ack_o   <= 1'b0;
            case (state)
                IDLE: begin
                    if (m0_req_i || m1_req_i) begin
                        owner        <= pick_m1;
                        lat_we       <= sel_we;
                        addr_o       <= sel_addr;
                        write_data_o <= sel_wdata;
                        grant_o      <= pick_m1 ? 2'b10 : 2'b01;
                        // Strobes are registered here so they are high during ISSUE.
                        write_en_o   <= sel_we;
                        read_en_o    <= !sel_we;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (lat_we) begin
                        m0_ack_o <= !owner;
                        m1_ack_o <= owner;
                        state    <= ACK;
                    end else begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (owner) begin
                        m1_rdata_o <= read_data_i;
                    end else begin
                        m0_rdata_o <= read_data_i;
                    end
                    m0_ack_o <= !owner;
                    m1_ack_o <= owner;
                    state    <= ACK;
                end
                ACK: begin
                    last_grant <= owner;
                    grant_o    <= 2'b00;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// tb/tb_reg_bus_arbiter.sv - scoreboard bench for reg_bus_arbiter
module tb_reg_bus_arbiter;

    typedef struct packed {
        logic       we;
        logic [6:0] addr;
        logic [7:0] wdata;
    } desc_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req [2];
    logic       req_we [2];
    logic [6:0] req_addr [2];
    logic [7:0] req_wdata [2];
    logic       ack_w [2];
    logic       m0_ack, m1_ack;
    logic [7:0] m0_rdata, m1_rdata;
    logic [1:0] grant;
    logic [6:0] addr_o;
    logic [7:0] write_data;
    logic       write_en, read_en;
    logic [7:0] read_data = 8'h00;

    int n_cmp = 0;
    int n_bad = 0;

    desc_t      q0 [$];
    desc_t      q1 [$];
    logic [7:0] mem [128];
    logic [7:0] refmem [128];

    always #5 clk = ~clk;

    reg_bus_arbiter #(.ADDR_WIDTH(7), .DATA_WIDTH(8)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_req_i(req[0]), .m0_we_i(req_we[0]), .m0_addr_i(req_addr[0]),
        .m0_wdata_i(req_wdata[0]), .m0_ack_o(m0_ack), .m0_rdata_o(m0_rdata),
        .m1_req_i(req[1]), .m1_we_i(req_we[1]), .m1_addr_i(req_addr[1]),
        .m1_wdata_i(req_wdata[1]), .m1_ack_o(m1_ack), .m1_rdata_o(m1_rdata),
        .grant_o(grant), .addr_o(addr_o), .write_data_o(write_data),
        .write_en_o(write_en), .read_en_o(read_en), .read_data_i(read_data)
    );

    assign ack_w[0] = m0_ack;
    assign ack_w[1] = m1_ack;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Register map: returns junk except in the cycle after a read strobe.
    always @(posedge clk) begin
        if (write_en) mem[addr_o] = write_data;
        read_data <= read_en ? mem[addr_o] : 8'($urandom);
    end

    // Reference model and monitor, sampled on the falling edge.
    int         cyc = 0;
    logic [1:0] prev_req = 2'b00;
    logic [1:0] prev_grant = 2'b00;
    logic       last_owner = 1'b1;
    logic       pend = 1'b0;
    logic       p_owner = 1'b0;
    logic       p_we = 1'b0;
    int         p_ack_cyc = 0;
    logic [7:0] p_rdata = 8'h00;
    logic [7:0] rd_m [2] = '{8'h00, 8'h00};
    logic       idle_chk = 1'b0;

    always @(negedge clk) begin
        logic  gev;
        logic  exp_owner;
        logic  a_owner;
        desc_t t;
        cyc++;
        if (rst) begin
            pend       = 1'b0;
            last_owner = 1'b1;
            rd_m[0]    = 8'h00;
            rd_m[1]    = 8'h00;
            idle_chk   = 1'b0;
            q0.delete();
            q1.delete();
            prev_grant = 2'b00;
        end else begin
            if (idle_chk) chk("grant_idle_after_ack", 32'(grant), 32'd0);
            idle_chk = 1'b0;
            if (write_en && read_en) chk("strobes_exclusive", 32'd1, 32'd0);
            gev = (grant != 2'b00) && (prev_grant == 2'b00);
            if (gev) begin
                if (prev_req == 2'b00) begin
                    chk("grant_without_req", 32'(grant), 32'd0);
                    exp_owner = grant[1];
                end else if (prev_req == 2'b11) begin
                    exp_owner = !last_owner;
                end else begin
                    exp_owner = prev_req[1];
                end
                chk("grant_owner", 32'(grant), exp_owner ? 32'd2 : 32'd1);
                if ((exp_owner ? q1.size() : q0.size()) == 0) begin
                    chk("grant_no_descriptor", 32'd1, 32'd0);
                end else begin
                    t = exp_owner ? q1.pop_front() : q0.pop_front();
                    chk("strobe_kind", {30'd0, write_en, read_en}, t.we ? 32'd2 : 32'd1);
                    chk("addr", 32'(addr_o), 32'(t.addr));
                    if (t.we) chk("wdata", 32'(write_data), 32'(t.wdata));
                    pend      = 1'b1;
                    p_owner   = exp_owner;
                    p_we      = t.we;
                    p_ack_cyc = cyc + (t.we ? 1 : 2);
                    p_rdata   = refmem[t.addr];
                    if (t.we) refmem[t.addr] = t.wdata;
                end
            end else if (write_en || read_en) begin
                chk("strobe_width", {30'd0, write_en, read_en}, 32'd0);
            end
            if (m0_ack && m1_ack) chk("acks_exclusive", 32'd1, 32'd0);
            if (m0_ack || m1_ack) begin
                a_owner = m1_ack;
                if (!pend) begin
                    chk("spurious_ack", {30'd0, m1_ack, m0_ack}, 32'd0);
                end else begin
                    chk("ack_owner", 32'(a_owner), 32'(p_owner));
                    chk("ack_latency", 32'(cyc), 32'(p_ack_cyc));
                    chk("grant_hold", 32'(grant), p_owner ? 32'd2 : 32'd1);
                    if (!p_we) rd_m[p_owner] = p_rdata;
                    chk("m0_rdata", 32'(m0_rdata), 32'(rd_m[0]));
                    chk("m1_rdata", 32'(m1_rdata), 32'(rd_m[1]));
                    last_owner = p_owner;
                    pend       = 1'b0;
                    idle_chk   = 1'b1;
                end
            end else if (pend && cyc > p_ack_cyc) begin
                chk("missing_ack", 32'd0, 32'd1);
                pend = 1'b0;
            end
            prev_grant = grant;
        end
        prev_req = {req[1], req[0]};
    end

    // Called at posedge+1; returns at posedge+1 after the edge that samples ack.
    task automatic do_txn(input int m, input logic w, input logic [6:0] a, input logic [7:0] d);
        desc_t t;
        bit    done;
        done         = 1'b0;
        req_we[m]    = w;
        req_addr[m]  = a;
        req_wdata[m] = d;
        req[m]       = 1'b1;
        t.we = w; t.addr = a; t.wdata = d;
        if (m == 0) q0.push_back(t);
        else        q1.push_back(t);
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (ack_w[m]) done = 1'b1;
        end
        @(posedge clk); #1;
        req[m] = 1'b0;
        if (!done) chk("ack_timeout", 32'(m), 32'hFFFF);
    endtask

    task automatic random_driver(input int m, input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            do_txn(m, 1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)), 8'($urandom));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 128; i++) begin
            mem[i]    = 8'(i * 37 + 5);
            refmem[i] = 8'(i * 37 + 5);
        end
        mem[13]    = 8'hFF;
        refmem[13] = 8'hFF;
        for (int m = 0; m < 2; m++) begin
            req[m] = 1'b0; req_we[m] = 1'b0; req_addr[m] = '0; req_wdata[m] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {m0_ack, m1_ack, grant, write_en, read_en, addr_o, write_data, m0_rdata, m1_rdata},
            32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Simultaneous writes straight after reset: m0 first, then m1.
        fork
            do_txn(0, 1'b1, 7'h20, 8'h11);
            do_txn(1, 1'b1, 7'h21, 8'h22);
        join
        do_txn(0, 1'b1, 7'h02, 8'hA5);
        do_txn(1, 1'b0, 7'h0D, 8'h00);
        @(negedge clk);
        chk("single_read_m1", 32'(m1_rdata), 32'hFF);
        chk("single_read_m0_untouched", 32'(m0_rdata), 32'h00);
        @(posedge clk); #1;
        do_txn(1, 1'b1, 7'h05, 8'h3C);
        do_txn(0, 1'b0, 7'h05, 8'h00);
        @(negedge clk);
        chk("mixed_readback", 32'(m0_rdata), 32'h3C);

        // Reset while an m0 read sits in CAPTURE.
        @(posedge clk); #1;
        begin
            desc_t t;
            bit    seen;
            seen = 1'b0;
            t.we = 1'b0; t.addr = 7'h11; t.wdata = 8'h00;
            req_we[0] = 1'b0; req_addr[0] = 7'h11; req[0] = 1'b1;
            q0.push_back(t);
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                if (read_en) seen = 1'b1;
            end
            if (!seen) chk("reset_test_read_strobe", 32'd0, 32'd1);
            @(posedge clk); #1;
            rst    = 1'b1;
            req[0] = 1'b0;
            @(posedge clk); #1;
            rst = 1'b0;
            @(negedge clk);
            chk("reset_mid_ack", {30'd0, m1_ack, m0_ack}, 32'd0);
            chk("reset_mid_m0_rdata", 32'(m0_rdata), 32'd0);
            chk("reset_mid_grant", 32'(grant), 32'd0);
            @(posedge clk); #1;
        end
        do_txn(1, 1'b1, 7'h33, 8'h5A);

        // Random contention: both requesters issue back-to-back traffic.
        fork
            random_driver(0, 40);
            random_driver(1, 40);
        join
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("final_idle_grant", 32'(grant), 32'd0);
        chk("final_queues_empty", 32'(q0.size() + q1.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
